// File: rtl/prefetch_unit.sv
// Instruction prefetch unit.
//
// Fetches sequential 32-bit instructions from instruction memory into a small
// circular queue and hands them one per cycle to decode through a set of
// output registers. A redirect flushes the queue and restarts fetching at a
// new address.
//
// Ports
//   clk            : clock, all state updates on the rising edge
//   rst            : asynchronous active-low reset
//   imem_req       : fetch request valid (queue not full, no redirect)
//   imem_addr      : fetch address (current fetch PC)
//   imem_ack       : memory accepts the request; imem_rdata valid this cycle
//   imem_rdata     : instruction word at imem_addr
//   redirect       : control-flow change, flush and refetch
//   redirect_addr  : new fetch address, sampled while redirect=1
//   stall          : downstream hold; output registers keep their value
//   instr_out      : registered instruction to decode (NOP when not valid)
//   pc_out         : registered address of instr_out
//   pc_step_out    : registered pc_out + 4
//   instr_valid    : instr_out is a real fetched instruction
//   q_count        : current queue occupancy
module prefetch_unit #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter logic [31:0]     NOP      = 32'h00000013
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       imem_req,
    output logic [XLEN-1:0]            imem_addr,
    input  logic                       imem_ack,
    input  logic [31:0]                imem_rdata,
    input  logic                       redirect,
    input  logic [XLEN-1:0]            redirect_addr,
    input  logic                       stall,
    output logic [31:0]                instr_out,
    output logic [XLEN-1:0]            pc_out,
    output logic [XLEN-1:0]            pc_step_out,
    output logic                       instr_valid,
    output logic [$clog2(DEPTH):0]     q_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    // Queue storage; contents are only ever read behind a valid count, so no reset.
    logic [31:0]     instr_mem [DEPTH];
    logic [XLEN-1:0] pc_mem    [DEPTH];

    logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [31:0]      instr_q, instr_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic [XLEN-1:0]  step_q, step_d;
    logic             valid_q, valid_d;

    logic push;
    logic pop;

    // Gated by rst so the request is low while reset is held.
    assign imem_req  = rst && !redirect && (count_q != CNT_W'(DEPTH));
    assign imem_addr = fetch_pc_q;

    assign push = imem_req && imem_ack;
    assign pop  = !stall && !redirect && (count_q != '0);

    assign instr_out   = instr_q;
    assign pc_out      = pc_q;
    assign pc_step_out = step_q;
    assign instr_valid = valid_q;
    assign q_count     = count_q;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        instr_d    = instr_q;
        pc_d       = pc_q;
        step_d     = step_q;
        valid_d    = valid_q;

        if (redirect) begin
            // Redirect wins over push, pop and stall; same-cycle rdata is dropped.
            fetch_pc_d = redirect_addr;
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
            instr_d    = NOP;
            valid_d    = 1'b0;
        end else begin
            if (push) begin
                fetch_pc_d = fetch_pc_q + XLEN'(4);
                tail_d     = tail_q + PTR_W'(1);
            end
            if (pop) begin
                instr_d = instr_mem[head_q];
                pc_d    = pc_mem[head_q];
                step_d  = pc_mem[head_q] + XLEN'(4);
                valid_d = 1'b1;
                head_d  = head_q + PTR_W'(1);
            end else if (!stall) begin
                // Empty and not stalled: bubble, PCs hold.
                instr_d = NOP;
                valid_d = 1'b0;
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[tail_q] <= imem_rdata;
            pc_mem[tail_q]    <= fetch_pc_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q <= RESET_PC;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            instr_q    <= NOP;
            pc_q       <= '0;
            step_q     <= XLEN'(4);
            valid_q    <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            instr_q    <= instr_d;
            pc_q       <= pc_d;
            step_q     <= step_d;
            valid_q    <= valid_d;
        end
    end

endmodule

// File: tb/tb_prefetch_unit.sv
module tb_prefetch_unit;

    localparam logic [31:0] NOP = 32'h00000013;
    localparam logic [31:0] KEY = 32'hCAFE0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata;
    logic        redirect = 1'b0;
    logic [31:0] redirect_addr = '0;
    logic        stall = 1'b0;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic [31:0] pc_step_out;
    logic        instr_valid;
    logic [2:0]  q_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Memory returns address-derived data.
    assign imem_rdata = imem_addr ^ KEY;

    always #5 clk = ~clk;

    prefetch_unit dut (
        .clk          (clk),
        .rst          (rst),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .redirect     (redirect),
        .redirect_addr(redirect_addr),
        .stall        (stall),
        .instr_out    (instr_out),
        .pc_out       (pc_out),
        .pc_step_out  (pc_step_out),
        .instr_valid  (instr_valid),
        .q_count      (q_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        imem_ack = 1'b0;
        stall    = 1'b0;
        redirect = 1'b0;
        rst      = 1'b0;
        step();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step();
        n_checks++;
        if (instr_out !== NOP) begin
            n_fail++; $display("FAIL reset_instr: got %h expected %h", instr_out, NOP);
        end
        n_checks++;
        if (instr_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid: got %b expected 0", instr_valid);
        end
        n_checks++;
        if (pc_out !== 32'h0 || pc_step_out !== 32'h4) begin
            n_fail++; $display("FAIL reset_pc: got %h/%h expected 0/4", pc_out, pc_step_out);
        end
        n_checks++;
        if (q_count !== 3'd0 || imem_req !== 1'b0 || imem_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_fetch: got cnt %0d req %b addr %h expected 0 0 0",
                     q_count, imem_req, imem_addr);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (imem_req !== 1'b1) begin
            n_fail++; $display("FAIL req_after_release: got %b expected 1", imem_req);
        end
    endtask

    task automatic test_stream();
        do_reset();
        imem_ack = 1'b1;
        step();
        n_checks++;
        if (imem_addr !== 32'h4 || q_count !== 3'd1 || instr_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stream_e1: got addr %h cnt %0d valid %b expected 4 1 0",
                     imem_addr, q_count, instr_valid);
        end
        for (int k = 0; k < 5; k++) begin
            step();
            n_checks++;
            if (instr_valid !== 1'b1 || pc_out !== 32'(4 * k) ||
                pc_step_out !== 32'(4 * k + 4) || instr_out !== (32'(4 * k) ^ KEY) ||
                imem_addr !== 32'(4 * k + 8)) begin
                n_fail++;
                $display("FAIL stream_%0d: got v%b pc %h step %h ins %h addr %h expected pc %h",
                         k, instr_valid, pc_out, pc_step_out, instr_out, imem_addr, 4 * k);
            end
        end
    endtask

    task automatic test_stall_fill();
        do_reset();
        imem_ack = 1'b1;
        stall    = 1'b1;
        repeat (6) step();
        n_checks++;
        if (q_count !== 3'd4 || imem_req !== 1'b0 || imem_addr !== 32'h10) begin
            n_fail++;
            $display("FAIL stall_full: got cnt %0d req %b addr %h expected 4 0 10",
                     q_count, imem_req, imem_addr);
        end
        n_checks++;
        if (instr_valid !== 1'b0 || instr_out !== NOP) begin
            n_fail++; $display("FAIL stall_hold: got v%b ins %h expected 0 %h",
                               instr_valid, instr_out, NOP);
        end
        stall = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            n_checks++;
            if (instr_valid !== 1'b1 || pc_out !== 32'(4 * k) ||
                instr_out !== (32'(4 * k) ^ KEY)) begin
                n_fail++;
                $display("FAIL drain_%0d: got v%b pc %h ins %h expected pc %h",
                         k, instr_valid, pc_out, instr_out, 4 * k);
            end
        end
    endtask

    task automatic test_ack_gap();
        do_reset();
        imem_ack = 1'b1;
        repeat (4) step();
        n_checks++;
        if (pc_out !== 32'h8 || q_count !== 3'd1 || imem_addr !== 32'h10) begin
            n_fail++;
            $display("FAIL gap_pre: got pc %h cnt %0d addr %h expected 8 1 10",
                     pc_out, q_count, imem_addr);
        end
        imem_ack = 1'b0;
        step();
        n_checks++;
        if (pc_out !== 32'hC || instr_valid !== 1'b1 || q_count !== 3'd0 ||
            imem_addr !== 32'h10) begin
            n_fail++;
            $display("FAIL gap_last: got pc %h v%b cnt %0d addr %h expected c 1 0 10",
                     pc_out, instr_valid, q_count, imem_addr);
        end
        repeat (2) begin
            step();
            n_checks++;
            if (instr_out !== NOP || instr_valid !== 1'b0 || pc_out !== 32'hC ||
                pc_step_out !== 32'h10 || imem_addr !== 32'h10 || imem_req !== 1'b1) begin
                n_fail++;
                $display("FAIL gap_bubble: got ins %h v%b pc %h step %h addr %h req %b",
                         instr_out, instr_valid, pc_out, pc_step_out, imem_addr, imem_req);
            end
        end
        imem_ack = 1'b1;
        repeat (2) step();
        n_checks++;
        if (instr_valid !== 1'b1 || pc_out !== 32'h10 || instr_out !== (32'h10 ^ KEY)) begin
            n_fail++; $display("FAIL gap_resume: got v%b pc %h ins %h expected 1 10 %h",
                               instr_valid, pc_out, instr_out, 32'h10 ^ KEY);
        end
    endtask

    task automatic test_redirect();
        do_reset();
        imem_ack = 1'b1;
        stall    = 1'b1;
        repeat (3) step();
        redirect      = 1'b1;
        redirect_addr = 32'h100;
        #1;
        n_checks++;
        if (imem_req !== 1'b0 || q_count !== 3'd3) begin
            n_fail++; $display("FAIL redir_req: got req %b cnt %0d expected 0 3",
                               imem_req, q_count);
        end
        step();
        redirect = 1'b0;
        n_checks++;
        if (q_count !== 3'd0 || instr_valid !== 1'b0 || instr_out !== NOP ||
            imem_addr !== 32'h100) begin
            n_fail++;
            $display("FAIL redir_flush: got cnt %0d v%b ins %h addr %h expected 0 0 nop 100",
                     q_count, instr_valid, instr_out, imem_addr);
        end
        stall = 1'b0;
        repeat (2) step();
        n_checks++;
        if (instr_valid !== 1'b1 || pc_out !== 32'h100 || instr_out !== (32'h100 ^ KEY)) begin
            n_fail++; $display("FAIL redir_first: got v%b pc %h ins %h expected 1 100",
                               instr_valid, pc_out, instr_out);
        end
        // Back-to-back redirects: the latest address wins.
        redirect      = 1'b1;
        redirect_addr = 32'h200;
        step();
        redirect_addr = 32'h300;
        step();
        redirect = 1'b0;
        n_checks++;
        if (imem_addr !== 32'h300 || q_count !== 3'd0 || instr_valid !== 1'b0) begin
            n_fail++; $display("FAIL redir_b2b: got addr %h cnt %0d v%b expected 300 0 0",
                               imem_addr, q_count, instr_valid);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        redirect      = 1'b1;
        redirect_addr = 32'hFFFF_FFFC;
        step();
        redirect = 1'b0;
        imem_ack = 1'b1;
        step();
        n_checks++;
        if (imem_addr !== 32'h0 || q_count !== 3'd1) begin
            n_fail++; $display("FAIL wrap_fetch: got addr %h cnt %0d expected 0 1",
                               imem_addr, q_count);
        end
        step();
        n_checks++;
        if (pc_out !== 32'hFFFF_FFFC || pc_step_out !== 32'h0 || instr_valid !== 1'b1) begin
            n_fail++; $display("FAIL wrap_out: got pc %h step %h v%b expected fffffffc 0 1",
                               pc_out, pc_step_out, instr_valid);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        imem_ack = 1'b1;
        repeat (3) step();
        stall = 1'b1;
        step();
        n_checks++;
        if (q_count !== 3'd2 || pc_out !== 32'h4 || instr_valid !== 1'b1) begin
            n_fail++; $display("FAIL areset_pre: got cnt %0d pc %h v%b expected 2 4 1",
                               q_count, pc_out, instr_valid);
        end
        #2;
        rst = 1'b0;
        #1;
        n_checks++;
        if (q_count !== 3'd0 || instr_valid !== 1'b0 || instr_out !== NOP ||
            pc_out !== 32'h0 || pc_step_out !== 32'h4 || imem_addr !== 32'h0 ||
            imem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL areset_now: got cnt %0d v%b ins %h pc %h step %h addr %h req %b",
                     q_count, instr_valid, instr_out, pc_out, pc_step_out, imem_addr, imem_req);
        end
        #1;
        rst   = 1'b1;
        stall = 1'b0;
        #1;
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            n_fail++; $display("FAIL areset_release: got req %b addr %h expected 1 0",
                               imem_req, imem_addr);
        end
        repeat (2) step();
        n_checks++;
        if (instr_valid !== 1'b1 || pc_out !== 32'h0 || instr_out !== KEY) begin
            n_fail++; $display("FAIL areset_first: got v%b pc %h ins %h expected 1 0 %h",
                               instr_valid, pc_out, instr_out, KEY);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall_fill();
        test_ack_gap();
        test_redirect();
        test_wrap();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/prefetch_unit.md
PREFETCH_UNIT -- requirements
Module: prefetch_unit

Interface
REQ-001 Parameter XLEN, default 32: address/PC width; instruction width fixed at 32.
REQ-002 Parameter DEPTH, default 4: instruction queue entries; power of two, >=2.
REQ-003 Parameter RESET_PC, default 0: first fetch address after reset.
REQ-004 Parameter NOP, default 32'h00000013: instruction emitted when no valid instruction is available.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-low (asserted at 0).
REQ-007 imem_req  output  1  fetch request valid.
REQ-008 imem_addr  output  XLEN  fetch address.
REQ-009 imem_ack  input  1  memory accepts request; data valid this cycle.
REQ-010 imem_rdata  input  32  instruction for imem_addr, valid when imem_req & imem_ack.
REQ-011 redirect  input  1  control-flow change: flush and refetch.
REQ-012 redirect_addr  input  XLEN  new fetch address, sampled when redirect=1.
REQ-013 stall  input  1  downstream hold; output registers keep value.
REQ-014 instr_out  output  32  registered instruction to decode.
REQ-015 pc_out  output  XLEN  registered address of instr_out.
REQ-016 pc_step_out  output  XLEN  registered pc_out+4.
REQ-017 instr_valid  output  1  instr_out is a real fetched instruction.
REQ-018 q_count  output  log2(DEPTH)+1  current queue occupancy.

Function
REQ-019 fetch_pc register SHALL drive imem_addr; imem_req SHALL be 1 iff q_count<DEPTH and redirect=0 (no dependence on stall or imem_ack).
REQ-020 Transfer occurs when imem_req & imem_ack; on transfer {imem_rdata, fetch_pc} SHALL be pushed at the tail and fetch_pc SHALL advance by 4 (mod 2^XLEN, wrap from all-ones-minus-3 to 0).
REQ-021 Without transfer or redirect, fetch_pc and imem_addr SHALL hold; imem_req may stay high indefinitely while imem_ack=0.
REQ-022 Queue SHALL be a circular buffer, head/tail pointers wrap modulo DEPTH; q_count SHALL never exceed DEPTH nor go below 0.
REQ-023 Pop occurs when stall=0, redirect=0 and q_count>0: head entry SHALL load instr_out/pc_out, pc_step_out=entry pc+4, instr_valid=1 next cycle.
REQ-024 stall=0, redirect=0, q_count=0: output regs SHALL load instr_out=NOP, instr_valid=0, pc_out/pc_step_out hold.
REQ-025 stall=1, redirect=0: output regs and head pointer SHALL hold; pushes continue while not full.
REQ-026 Simultaneous push and pop SHALL both take effect, q_count unchanged; push to a full queue impossible (REQ-019); pop then push at full lands next cycle.
REQ-027 Entry pushed into empty queue SHALL be poppable no earlier than the following cycle (latency ack->instr_out valid = 2 edges minimum).
REQ-028 redirect=1 SHALL, at the next edge and regardless of stall or imem_ack: flush queue (q_count=0, pointers equal), set fetch_pc=redirect_addr, load instr_out=NOP, instr_valid=0; any same-cycle imem_rdata is discarded.
REQ-029 redirect SHALL take priority over push, pop and stall; consecutive redirect cycles SHALL each take the latest redirect_addr.
REQ-030 No X SHALL propagate to outputs after reset; unused queue contents need no reset.

Reset
REQ-031 rst=0 SHALL asynchronously force: fetch_pc=RESET_PC, q_count=0, pointers=0, instr_out=NOP, instr_valid=0, pc_out=0, pc_step_out=4, imem_req low during reset.
REQ-032 Reset mid-operation SHALL discard all queued and in-flight data; first request after release SHALL use RESET_PC.
REQ-033 After rst rises, imem_req SHALL assert in the first cycle (queue empty).

Verification
REQ-034 Reset, imem_ack=1 always, stall=0, memory returns addr-based data -> imem_addr 0,4,8,...; instr_out first valid with pc_out=0 on 2nd edge, then one per cycle, pc_step_out=pc_out+4.
REQ-035 stall=1 held, imem_ack=1 -> exactly DEPTH (4) pushes, q_count=4, imem_req=0, imem_addr=0x10; release stall -> instr_out pcs 0,4,8,C in order, no gap or duplicate.
REQ-036 imem_ack=0 for 3 cycles mid-stream -> imem_addr held, queue drains, instr_out=NOP with instr_valid=0 once empty; ack resumes stream at held address.
REQ-037 redirect=1, redirect_addr=0x100 with q_count=3, stall=1 and imem_ack=1 same cycle -> next cycle q_count=0, instr_valid=0, imem_addr=0x100; next valid instr has pc_out=0x100.
REQ-038 fetch_pc=0xFFFFFFFC, transfer -> fetch_pc wraps to 0x0; queued entry pc_step_out=0x0.
REQ-039 rst asserted asynchronously between edges with q_count=2 -> outputs immediately at reset values; after release first imem_addr=RESET_PC.
